// File: rtl/ntt_layer_sequencer.sv
// ntt_layer_sequencer: holds one polynomial, runs a single NTT layer through an external butterfly, streams it back out.
// Latency: N load + N/2 issue + BF_LAT+1 flush + N+1 unload cycles when neither stream stalls.
// Backpressure: in_ready only while loading, out_data held while out_valid&!out_ready; `PERF_CNT_EN adds perf_cycles.

// Small generic FIFO; push while full is legal only together with a pop.
module ntt_seq_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         r,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  // storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end
endmodule

module ntt_layer_sequencer #(
  parameter int N      = 256,
  parameter int BF_LAT = 3,
  parameter int AW     = 8
) (
  input  logic          clk,
  input  logic          r,
  input  logic          start,
  input  logic [AW-1:0] len,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [11:0]   in_data,
  output logic [11:0]   bf_in1,
  output logic [11:0]   bf_in2,
  output logic          bf_valid_in,
  input  logic          bf_valid_out,
  input  logic [11:0]   bf_u,
  input  logic [11:0]   bf_v,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [11:0]   out_data,
  output logic          busy,
  output logic          done
`ifdef PERF_CNT_EN
  ,
  output logic [15:0]   perf_cycles
`endif
);
  localparam int HALF = N / 2;
  localparam logic [AW-1:0] LAST_IDX  = AW'(N - 1);
  localparam logic [AW-1:0] LAST_PAIR = AW'(HALF - 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, FLUSH, UNLOAD} state_t;
  state_t state;

  logic [11:0]   coef_mem [N];
  logic [AW-1:0] len_q, ld_cnt, iss_cnt, wb_cnt, ul_cnt;
  logic [AW-1:0] pair_j, wb_j;
  logic          len_ok, issue_push, fifo_empty, wb_fire, wb_last;
  logic [AW:0]   fifo_in, fifo_out;

  assign len_ok = (len != '0) && ((len & (len - 1'b1)) == '0) && (len <= AW'(HALF));
  // Pair p maps to j = base + k where k = p mod len and base = 2*(p - k).
  assign pair_j = iss_cnt + (iss_cnt & ~(len_q - 1'b1));

  // Every beat sent to the butterfly is tracked, flush fillers tagged not-real, so
  // filler results still in its pipeline when the next layer starts are dropped.
  assign fifo_in    = {state == ISSUE, pair_j};
  assign issue_push = (state == ISSUE) || ((state == FLUSH) && !wb_last);
  assign wb_j       = fifo_out[AW-1:0];
  assign wb_fire    = bf_valid_out && !fifo_empty && fifo_out[AW] &&
                      ((state == ISSUE) || (state == FLUSH));
  assign wb_last    = wb_fire && (wb_cnt == LAST_PAIR);

  ntt_seq_fifo #(.W(AW + 1), .DEPTH(BF_LAT + 1)) u_addr_fifo (
    .clk      (clk),
    .r        (r),
    .push     (issue_push),
    .push_dat (fifo_in),
    .pop      (bf_valid_out),
    .pop_dat  (fifo_out),
    .empty    (fifo_empty)
  );

  // coefficient buffer: load beats and in-place butterfly write-back
  always_ff @(posedge clk) begin
    if ((state == LOAD) && in_valid && in_ready) coef_mem[ld_cnt] <= in_data;
    if (wb_fire) begin
      coef_mem[wb_j]         <= bf_u;
      coef_mem[wb_j + len_q] <= bf_v;
    end
  end

  // layer control FSM with registered stream and butterfly outputs
  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state       <= IDLE;
      len_q       <= '0;
      ld_cnt      <= '0;
      iss_cnt     <= '0;
      wb_cnt      <= '0;
      ul_cnt      <= '0;
      in_ready    <= 1'b0;
      bf_valid_in <= 1'b0;
      bf_in1      <= '0;
      bf_in2      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef PERF_CNT_EN
      perf_cycles <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (wb_fire) wb_cnt <= wb_cnt + 1'b1;
`ifdef PERF_CNT_EN
      if ((state == ISSUE) || (state == FLUSH)) perf_cycles <= perf_cycles + 1'b1;
`endif
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            state    <= LOAD;
            len_q    <= len;
            ld_cnt   <= '0;
            iss_cnt  <= '0;
            wb_cnt   <= '0;
            ul_cnt   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
`ifdef PERF_CNT_EN
            perf_cycles <= '0;
`endif
          end
        end
        LOAD: begin
          if (in_valid) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LAST_IDX) begin
              state    <= ISSUE;
              in_ready <= 1'b0;
            end
          end
        end
        ISSUE: begin
          bf_valid_in <= 1'b1;
          bf_in1      <= coef_mem[pair_j];
          bf_in2      <= coef_mem[pair_j + len_q];
          iss_cnt     <= iss_cnt + 1'b1;
          if (iss_cnt == LAST_PAIR) state <= FLUSH;
        end
        FLUSH: begin
          // zero fillers keep the butterfly advancing until the last real result lands
          bf_in1 <= '0;
          bf_in2 <= '0;
          if (wb_last) begin
            state       <= UNLOAD;
            bf_valid_in <= 1'b0;
          end else begin
            bf_valid_in <= 1'b1;
          end
        end
        UNLOAD: begin
          if (!out_valid) begin
            out_data  <= coef_mem[ul_cnt];
            out_valid <= 1'b1;
          end else if (out_ready) begin
            if (ul_cnt == LAST_IDX) begin
              out_valid <= 1'b0;
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_data <= coef_mem[ul_cnt + 1'b1];
              ul_cnt   <= ul_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_layer_sequencer.sv
// tb_ntt_layer_sequencer: drives load/unload streams around a twiddle=1 butterfly model.
// Expected coefficients are pushed to a queue once a polynomial is loaded and popped per output beat.
// Covers reset abort, several layer lengths, stream backpressure and ignored starts.
module tb_ntt_layer_sequencer;
  localparam int N      = 256;
  localparam int BF_LAT = 3;
  localparam int AW     = 8;
  localparam int HALF   = N / 2;
  localparam int Q      = 3329;

  logic          clk = 1'b0;
  logic          r;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [11:0]   in_data = '0;
  logic [11:0]   bf_in1, bf_in2;
  logic          bf_valid_in, bf_valid_out;
  logic [11:0]   bf_u, bf_v;
  logic          out_valid;
  logic          out_ready;
  logic [11:0]   out_data;
  logic          busy, done;
`ifdef PERF_CNT_EN
  logic [15:0]   perf_cycles;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int vin_cnt = 0;
  int out_cnt = 0;
  int bp = 0;
  int ld [N];
  int exp_q [$];
  bit stall_pend = 1'b0;
  logic [11:0] stall_dat = '0;

  always #5 clk = ~clk;

  ntt_layer_sequencer #(.N(N), .BF_LAT(BF_LAT), .AW(AW)) dut (
    .clk          (clk),
    .r            (r),
    .start        (start),
    .len          (len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .bf_in1       (bf_in1),
    .bf_in2       (bf_in2),
    .bf_valid_in  (bf_valid_in),
    .bf_valid_out (bf_valid_out),
    .bf_u         (bf_u),
    .bf_v         (bf_v),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .done         (done)
`ifdef PERF_CNT_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Butterfly model, twiddle=1: advances only on valid_in beats, BF_LAT beats deep.
  logic [BF_LAT-1:0] s_vld;
  logic [11:0] s_u [BF_LAT];
  logic [11:0] s_v [BF_LAT];
  logic fresh;
  always @(posedge clk or negedge r) begin
    if (!r) begin
      s_vld <= '0;
      fresh <= 1'b0;
    end else begin
      fresh <= bf_valid_in;
      if (bf_valid_in) begin
        for (int i = BF_LAT - 1; i > 0; i--) begin
          s_vld[i] <= s_vld[i-1];
          s_u[i]   <= s_u[i-1];
          s_v[i]   <= s_v[i-1];
        end
        s_vld[0] <= 1'b1;
        s_u[0]   <= 12'((int'(bf_in1) + int'(bf_in2)) % Q);
        s_v[0]   <= 12'((int'(bf_in1) + Q - int'(bf_in2)) % Q);
      end
    end
  end
  assign bf_valid_out = fresh && s_vld[BF_LAT-1];
  assign bf_u = s_u[BF_LAT-1];
  assign bf_v = s_v[BF_LAT-1];

  // out_ready: always ready, or 50% random while backpressure is enabled
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = (bp != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard pop, stall stability, event counters.
  always @(negedge clk) begin
    if (r) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        out_cnt++;
      end
      if (stall_pend) chk("stall_stable", {out_valid, out_data}, {1'b1, stall_dat});
      stall_pend = out_valid && !out_ready;
      stall_dat  = out_data;
      if (done) done_cnt++;
      if (bf_valid_in) vin_cnt++;
    end else begin
      stall_pend = 1'b0;
    end
  end

  // Reference layer over the loaded polynomial, results queued in index order.
  task automatic push_expected(input int l);
    int m [N];
    for (int i = 0; i < N; i++) m[i] = ld[i];
    for (int base = 0; base < N; base += 2 * l) begin
      for (int k = 0; k < l; k++) begin
        int a, b;
        a = m[base + k];
        b = m[base + k + l];
        m[base + k]     = (a + b) % Q;
        m[base + k + l] = (a - b + Q) % Q;
      end
    end
    for (int i = 0; i < N; i++) exp_q.push_back(m[i]);
  endtask

  task automatic pulse_start(input int l);
    start = 1'b1;
    len   = AW'(l);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic load_poly(input int gaps, input int mid);
    int i, guard;
    logic fire;
    i = 0;
    guard = 0;
    while (i < N && guard < 20000) begin
      in_valid = (gaps != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = 12'(ld[i]);
      if (mid != 0 && guard == 5) begin
        start = 1'b1;
        len   = AW'(1);
      end
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (fire) i++;
      start = 1'b0;
      if (mid != 0 && guard == 5) chk("start_while_busy", {busy, in_ready}, 2'b11);
      guard++;
    end
    in_valid = 1'b0;
    chk("load_beats", i, N);
  endtask

  task automatic run_layer(input int l, input int gaps, input int mid);
    int d0, v0, o0, c, nv;
    d0 = done_cnt;
    v0 = vin_cnt;
    o0 = out_cnt;
    pulse_start(l);
    chk("busy_after_start", busy, 1);
    load_poly(gaps, mid);
    push_expected(l);
    c = 0;
    while (done_cnt == d0 && c < 20000) begin
      @(posedge clk);
      c++;
    end
    repeat (3) @(posedge clk);
    #1;
    nv = vin_cnt - v0;
    chk("done_once", done_cnt - d0, 1);
    chk("out_count", out_cnt - o0, N);
    chk("queue_drained", exp_q.size(), 0);
    chk("vin_beats_in_range", (nv >= HALF && nv <= HALF + BF_LAT), 1);
    chk("idle_outputs", {busy, bf_valid_in, out_valid, in_ready}, 4'b0000);
`ifdef PERF_CNT_EN
    chk("perf_cycles", perf_cycles, HALF + BF_LAT + 1);
`endif
  endtask

  initial begin
    int c, d0;
    r = 1'b1;
    #1 r = 1'b0;
    #2;
    chk("reset_outputs", {busy, bf_valid_in, out_valid, in_ready, done}, 5'b00000);
    repeat (3) @(posedge clk);
    #1 r = 1'b1;
    @(posedge clk);
    #1;

    // Abort mid-ISSUE with reset; nothing may complete.
    for (int i = 0; i < N; i++) ld[i] = i;
    d0 = done_cnt;
    pulse_start(128);
    load_poly(0, 0);
    c = 0;
    while (!bf_valid_in && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("reached_issue", bf_valid_in, 1);
    repeat (10) @(posedge clk);
    #2 r = 1'b0;
    #1;
    chk("abort_outputs", {busy, bf_valid_in, out_valid, in_ready, done}, 5'b00000);
    repeat (3) @(posedge clk);
    #1 r = 1'b1;
    @(posedge clk);
    #1;
    chk("after_release", {busy, bf_valid_in, out_valid, in_ready, done}, 5'b00000);
    chk("no_partial_done", done_cnt - d0, 0);

    // len=128, ramp data
    for (int i = 0; i < N; i++) ld[i] = i;
    run_layer(128, 0, 0);

    // len=1, constant 5
    for (int i = 0; i < N; i++) ld[i] = 5;
    run_layer(1, 0, 0);

    // ramp again with random load gaps and output backpressure
    for (int i = 0; i < N; i++) ld[i] = i;
    bp = 1;
    run_layer(128, 1, 0);
    bp = 0;

    // invalid lengths in IDLE are ignored
    pulse_start(3);
    repeat (2) @(posedge clk);
    #1;
    chk("len3_ignored", {busy, in_ready}, 2'b00);
    pulse_start(0);
    repeat (2) @(posedge clk);
    #1;
    chk("len0_ignored", {busy, in_ready}, 2'b00);

    // random data, len=16, with a start(len=1) during LOAD that must be ignored
    for (int i = 0; i < N; i++) ld[i] = int'($urandom_range(0, Q - 1));
    run_layer(16, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
